// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiplier FSM states and datapath widths.
// Imported by the MUL unit and its iteration adder.
package cpu_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  localparam int WORD_W   = 16;
  localparam int MUL_ITER = 16;

  localparam logic [4:0] MUL_LAST = 5'(MUL_ITER - 1);

endpackage

// File: rtl/sixteenBit_FA.sv
// 16-bit ripple-carry adder built from bitwise full-adder cells.
// Used as the single per-iteration adder of the MUL unit.
module sixteenBit_FA
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              c
);

  logic [WORD_W:0] cy;

  always_comb begin
    cy    = '0;
    s     = '0;
    cy[0] = cin;
    for (int i = 0; i < WORD_W; i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign c = cy[WORD_W];

endmodule

// File: rtl/seq_mul16.sv
// Unsigned 16x16->32 shift-and-add multiplier, one add per clock.
// Result and overflow flag land 17 cycles after an accepted start.
module seq_mul16
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  if (WIDTH != WORD_W) begin : g_width_chk
    $error("seq_mul16: only WIDTH=16 is supported");
  end

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  assign add_b = lo_q[0] ? m_q : '0;

  sixteenBit_FA u_add (
    .a   (hi_q),
    .b   (add_b),
    .cin (1'b0),
    .s   (add_s),
    .c   (add_c)
  );

  // {c,s,lo} shifted right by one; carry enters hi[15]
  assign nxt_hi = {add_c, add_s[WIDTH-1:1]};
  assign nxt_lo = {add_s[0], lo_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      MUL_IDLE, MUL_DONE: begin
        state_d = MUL_IDLE;
        if (start) begin
          m_d     = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        hi_d  = nxt_hi;
        lo_d  = nxt_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) begin
          prod_d  = {nxt_hi, nxt_lo};
          ovf_d   = |nxt_hi;
          state_d = MUL_DONE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MUL_IDLE;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == MUL_RUN);
  assign done    = (state_q == MUL_DONE);
  assign product = prod_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_mul16.sv
// Self-checking bench for seq_mul16 using an expected-result queue.
// Each scenario task drives operands and checks outputs inline.
module tb_seq_mul16;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;

  seq_mul16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .a       (op_a),
    .b       (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    e.prod = {16'h0, x} * {16'h0, y};
    e.ovf  = |e.prod[31:16];
    return e;
  endfunction

  // Drives start on a negedge; the following posedge accepts it.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    op_a  = x;
    op_b  = y;
    start = 1'b1;
    sb.push_back(model(x, y));
  endtask

  // Returns negedges from start to done, or -1 on timeout.
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    start  = 1'b0;
    op_a   = '0;
    op_b   = '0;
    #3 resetn = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done got=%b want=0", done);
    end
    total++;
    if (product !== 32'h0) begin
      bad++;
      $display("FAIL reset_product got=%h want=0", product);
    end
    total++;
    if (ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b want=0", ovf);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int   n;
    int   busy_bad;
    int   lat;
    exp_t e;
    start_op(16'd3, 16'd5);
    n = 0;
    busy_bad = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n <= 16 && (busy !== 1'b1 || done !== 1'b0)) busy_bad++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL basic_busy bad_cycles=%0d want=0", busy_bad);
    end
    total++;
    if (lat != 17) begin
      bad++;
      $display("FAIL basic_latency got=%0d want=17", lat);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_in_done got=%b want=0", busy);
    end
    e = sb.pop_front();
    total++;
    if (product !== e.prod || ovf !== e.ovf) begin
      bad++;
      $display("FAIL basic_result got=%h/%b want=%h/%b",
               product, ovf, e.prod, e.ovf);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_pulse got=%b want=0", done);
    end
  endtask

  task automatic test_corners();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    int   lat;
    exp_t e;
    va = '{16'hFFFF, 16'h1234, 16'h0000, 16'h0100};
    vb = '{16'hFFFF, 16'h0000, 16'hBEEF, 16'h0100};
    for (int i = 0; i < 4; i++) begin
      start_op(va[i], vb[i]);
      wait_done(lat);
      total++;
      if (lat != 17) begin
        bad++;
        $display("FAIL corner%0d_latency got=%0d want=17", i, lat);
      end
      e = sb.pop_front();
      total++;
      if (product !== e.prod || ovf !== e.ovf) begin
        bad++;
        $display("FAIL corner%0d_result got=%h/%b want=%h/%b",
                 i, product, ovf, e.prod, e.ovf);
      end
    end
    total++;
    if (product !== 32'h0001_0000 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL corner_pow2 got=%h/%b want=00010000/1", product, ovf);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int   n;
    int   lat;
    int   extra;
    exp_t e;
    start_op(16'd7, 16'd6);
    n = 0;
    lat = -1;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 5) begin
        op_a  = 16'd9;
        op_b  = 16'd9;
        start = 1'b1;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat != 17) begin
      bad++;
      $display("FAIL ignore_latency got=%0d want=17", lat);
    end
    e = sb.pop_front();
    total++;
    if (product !== e.prod || product !== 32'h2A || ovf !== e.ovf) begin
      bad++;
      $display("FAIL ignore_result got=%h/%b want=0000002a/0", product, ovf);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_extra_done got=%0d want=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   lat;
    int   held_bad;
    exp_t e;
    start_op(16'd7, 16'd6);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat != 17 || product !== e.prod) begin
      bad++;
      $display("FAIL b2b_first got=%h lat=%0d want=%h lat=17",
               product, lat, e.prod);
    end
    op_a  = 16'd2;
    op_b  = 16'h8000;
    start = 1'b1;
    sb.push_back(model(16'd2, 16'h8000));
    n = 0;
    lat = -1;
    held_bad = 0;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL b2b_busy got=%b want=1", busy);
        end
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (product !== 32'h2A || ovf !== 1'b0) held_bad++;
    end
    total++;
    if (held_bad != 0) begin
      bad++;
      $display("FAIL b2b_hold bad_cycles=%0d want=0", held_bad);
    end
    total++;
    if (lat != 17) begin
      bad++;
      $display("FAIL b2b_latency got=%0d want=17", lat);
    end
    e = sb.pop_front();
    total++;
    if (product !== e.prod || ovf !== e.ovf) begin
      bad++;
      $display("FAIL b2b_result got=%h/%b want=%h/%b",
               product, ovf, e.prod, e.ovf);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int   n;
    int   lat;
    int   seen;
    exp_t e;
    start_op(16'hFFFF, 16'hFFFF);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    #2 resetn = 1'b0;
    sb.delete();
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs got=%b/%b/%h/%b want=0/0/0/0",
               busy, done, product, ovf);
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_idle active_cycles=%0d want=0", seen);
    end
    start_op(16'd3, 16'd5);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat != 17 || product !== e.prod || product !== 32'hF) begin
      bad++;
      $display("FAIL abort_rerun got=%h lat=%0d want=0000000f lat=17",
               product, lat);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
